load_store_unit: RTL and testbench

//  Initiator side of the byte-addressed data RAM port (addr/width/write/din/dout, 1-cycle registered read).

---
 rtl/load_store_unit.sv | 150 +++++++++++++++
 tb/tb_load_store_unit.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// load_store_unit
//   Initiator side of a byte-addressed data RAM port with a 1-cycle registered read.
//   It takes one RV32 load/store at a time from the execute stage and checks funct3,
//   alignment and range. It then drives the RAM, sign- or zero-extends the load data
//   and holds the response until the pipeline consumes it.
//
// Ports
//   clk, rst                 clock and synchronous active-high reset
//   req_valid/req_ready      request handshake (ready only in IDLE, out of reset)
//   req_write, req_funct3    1=store / 0=load, RV32 funct3 (size and signedness)
//   req_addr, req_wdata      byte address and store data (low bytes used by the RAM)
//   resp_valid/resp_ready    response handshake; response held until consumed
//   resp_rdata, resp_err     extended load data (0 for stores/faults), fault flag
//   mem_addr/width/din       registered RAM address, width (00 b, 01 h, 10 w), write data
//   mem_write                RAM write strobe, only during the ACCESS cycle of a store
//   mem_dout                 RAM read data, valid the cycle after the address is presented
module load_store_unit #(
  parameter int          WORD    = 32,
  parameter int          ADDR    = 32,
  parameter int unsigned MEM_LEN = 65535
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_write,
  input  logic [2:0]      req_funct3,
  input  logic [ADDR-1:0] req_addr,
  input  logic [WORD-1:0] req_wdata,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [WORD-1:0] resp_rdata,
  output logic            resp_err,
  output logic [ADDR-1:0] mem_addr,
  output logic [1:0]      mem_width,
  output logic            mem_write,
  output logic [WORD-1:0] mem_din,
  input  logic [WORD-1:0] mem_dout
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ACCESS  = 2'd1;
  localparam logic [1:0] S_CAPTURE = 2'd2;
  localparam logic [1:0] S_RESP    = 2'd3;

  logic [1:0]      r_state;
  logic            r_write;
  logic [2:0]      r_funct3;
  logic [ADDR-1:0] r_mem_addr;
  logic [1:0]      r_mem_width;
  logic [WORD-1:0] r_mem_din;
  logic [WORD-1:0] r_resp_rdata;
  logic            r_resp_err;

  logic            w_accept;
  logic            w_bad_funct3;
  logic            w_misaligned;
  logic            w_out_of_range;
  logic            w_fault;
  logic [1:0]      w_size_m1;
  logic [ADDR:0]   w_last_byte;
  logic [WORD-1:0] w_load_ext;

  assign req_ready  = (r_state == S_IDLE) && !rst;
  assign w_accept   = req_valid && req_ready;
  assign resp_valid = (r_state == S_RESP);
  assign resp_rdata = r_resp_rdata;
  assign resp_err   = r_resp_err;
  assign mem_addr   = r_mem_addr;
  assign mem_width  = r_mem_width;
  assign mem_din    = r_mem_din;

  // Gated by rst so that a reset landing on the closing edge of a store ACCESS
  // cannot let the RAM commit the write.
  assign mem_write  = (r_state == S_ACCESS) && r_write && !rst;

  // Loads allow the unsigned variants (1xx except 110/111); stores only 000..010.
  always_comb begin
    if (req_write) begin
      w_bad_funct3 = req_funct3[2] || (req_funct3[1:0] == 2'b11);
    end else begin
      w_bad_funct3 = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) ||
                     (req_funct3 == 3'b111);
    end
  end

  assign w_misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                        ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));

  // Access size minus one: byte 0, half 1, word 3.
  assign w_size_m1 = {req_funct3[1], req_funct3[1] | req_funct3[0]};

  // One extra bit so an access near the top of the address space cannot wrap
  // around to a small, apparently valid, byte index.
  assign w_last_byte    = {1'b0, req_addr} + {{(ADDR-1){1'b0}}, w_size_m1};
  assign w_out_of_range = (w_last_byte > (ADDR+1)'(MEM_LEN));

  assign w_fault = w_bad_funct3 || w_misaligned || w_out_of_range;

  always_comb begin
    case (r_funct3)
      3'b000:  w_load_ext = {{(WORD-8){mem_dout[7]}},   mem_dout[7:0]};
      3'b001:  w_load_ext = {{(WORD-16){mem_dout[15]}}, mem_dout[15:0]};
      3'b100:  w_load_ext = {{(WORD-8){1'b0}},          mem_dout[7:0]};
      3'b101:  w_load_ext = {{(WORD-16){1'b0}},         mem_dout[15:0]};
      default: w_load_ext = mem_dout;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_write      <= 1'b0;
      r_funct3     <= 3'b010;
      r_mem_addr   <= '0;
      r_mem_width  <= 2'b10;
      r_mem_din    <= '0;
      r_resp_rdata <= '0;
      r_resp_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_write      <= req_write;
            r_funct3     <= req_funct3;
            r_mem_addr   <= req_addr;
            r_mem_width  <= req_funct3[1:0];
            r_mem_din    <= req_wdata;
            r_resp_rdata <= '0;
            r_resp_err   <= w_fault;
            r_state      <= w_fault ? S_RESP : S_ACCESS;
          end
        end
        S_ACCESS: begin
          r_state <= r_write ? S_RESP : S_CAPTURE;
        end
        S_CAPTURE: begin
          r_resp_rdata <= w_load_ext;
          r_state      <= S_RESP;
        end
        default: begin
          if (resp_ready) begin
            r_state <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a little-endian byte RAM model
// (registered read) attached to the mem_* port.
module tb_load_store_unit;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [1:0]  mem_width;
  logic        mem_write;
  logic [31:0] mem_din;
  logic [31:0] mem_dout;

  int n_checks = 0;
  int n_errors = 0;
  int wr_cnt   = 0;

  load_store_unit #(.WORD(32), .ADDR(32), .MEM_LEN(65535)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_addr   (mem_addr),
    .mem_width  (mem_width),
    .mem_write  (mem_write),
    .mem_din    (mem_din),
    .mem_dout   (mem_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: 64 KiB, little-endian, address wraps in 16 bits for the
  // harmless reads issued while the unit is idle.
  logic [7:0]  ram [0:65535];
  logic [15:0] a0, a1, a2, a3;
  assign a0 = mem_addr[15:0];
  assign a1 = a0 + 16'd1;
  assign a2 = a0 + 16'd2;
  assign a3 = a0 + 16'd3;

  always @(posedge clk) begin
    mem_dout <= {ram[a3], ram[a2], ram[a1], ram[a0]};
    if (mem_write) begin
      wr_cnt <= wr_cnt + 1;
      ram[a0] <= mem_din[7:0];
      if (mem_width != 2'b00) ram[a1] <= mem_din[15:8];
      if (mem_width == 2'b10) begin
        ram[a2] <= mem_din[23:16];
        ram[a3] <= mem_din[31:24];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic send(input logic w, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] d);
    int k;
    k = 0;
    while (!req_ready && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    check("req_ready_before_send", req_ready, 1);
    req_valid  = 1'b1;
    req_write  = w;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = d;
    @(posedge clk); #1;
    req_valid  = 1'b0;
  endtask

  // Latency counted in clock edges from the accepting edge (that edge = 1).
  task automatic wait_resp(output int lat);
    lat = 1;
    while (!resp_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic consume();
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  task automatic txn(input string tag, input logic w, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] d,
                     input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat);
    int lat;
    send(w, f3, a, d);
    wait_resp(lat);
    check({tag, "_valid"}, resp_valid, 1);
    check({tag, "_rdata"}, resp_rdata, exp_rdata);
    check({tag, "_err"},   resp_err, exp_err);
    check({tag, "_lat"},   lat, exp_lat);
    $display("txn %-8s w=%0d f3=%03b addr=0x%08h wdata=0x%08h -> rdata=0x%08h err=%0d lat=%0d",
             tag, w, f3, a, d, resp_rdata, resp_err, lat);
    consume();
    check({tag, "_released"}, resp_valid, 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int w0;
    for (int i = 0; i < 65536; i++) ram[i] = 8'h00;
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Reset state
    check("rst_req_ready", req_ready, 0);
    check("rst_mem_write", mem_write, 0);
    rst = 1'b0;
    #1;
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_rdata", resp_rdata, 32'h0);
    check("rst_resp_err",   resp_err, 0);
    check("rst_mem_addr",   mem_addr, 32'h0);
    check("rst_mem_width",  mem_width, 2'b10);
    check("rst_mem_din",    mem_din, 32'h0);
    check("idle_req_ready", req_ready, 1);

    // Word store, with the RAM-side signals observed in ACCESS
    send(1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
    check("sw10_mem_write", mem_write, 1);
    check("sw10_mem_addr",  mem_addr, 32'h10);
    check("sw10_mem_width", mem_width, 2'b10);
    check("sw10_mem_din",   mem_din, 32'hDEADBEEF);
    wait_resp(lat);
    check("sw10_rdata", resp_rdata, 32'h0);
    check("sw10_err",   resp_err, 0);
    check("sw10_lat",   lat, 2);
    $display("txn sw10     w=1 f3=010 addr=0x00000010 wdata=0xdeadbeef -> err=%0d lat=%0d",
             resp_err, lat);
    consume();

    txn("lw10",  1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 3);
    txn("lb13",  1'b0, 3'b000, 32'h13, 32'h0, 32'hFFFFFFDE, 1'b0, 3);
    txn("lh12",  1'b0, 3'b001, 32'h12, 32'h0, 32'hFFFFDEAD, 1'b0, 3);
    txn("sb21",  1'b1, 3'b000, 32'h21, 32'h80, 32'h0, 1'b0, 2);
    txn("lb21",  1'b0, 3'b000, 32'h21, 32'h0, 32'hFFFFFF80, 1'b0, 3);
    txn("lbu21", 1'b0, 3'b100, 32'h21, 32'h0, 32'h00000080, 1'b0, 3);
    txn("lh20",  1'b0, 3'b001, 32'h20, 32'h0, 32'hFFFF8000, 1'b0, 3);
    txn("lhu20", 1'b0, 3'b101, 32'h20, 32'h0, 32'h00008000, 1'b0, 3);

    // Faults: 1-cycle error response, no RAM write
    w0 = wr_cnt;
    txn("lw12",  1'b0, 3'b010, 32'h12, 32'h0, 32'h0, 1'b1, 1);
    txn("sh13",  1'b1, 3'b001, 32'h13, 32'hFFFF, 32'h0, 1'b1, 1);
    txn("ld011", 1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1, 1);
    txn("ld110", 1'b0, 3'b110, 32'h10, 32'h0, 32'h0, 1'b1, 1);
    txn("st100", 1'b1, 3'b100, 32'h30, 32'h55, 32'h0, 1'b1, 1);
    txn("st011", 1'b1, 3'b011, 32'h30, 32'h55, 32'h0, 1'b1, 1);
    check("fault_no_writes", wr_cnt, w0);
    txn("lw10b", 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 3);
    txn("lw14",  1'b0, 3'b010, 32'h14, 32'h0, 32'h0, 1'b0, 3);

    // Range boundaries around MEM_LEN = 0xFFFF
    txn("swfffc",  1'b1, 3'b010, 32'hFFFC, 32'hCAFEF00D, 32'h0, 1'b0, 2);
    txn("lwfffc",  1'b0, 3'b010, 32'hFFFC, 32'h0, 32'hCAFEF00D, 1'b0, 3);
    txn("lhfffe",  1'b0, 3'b001, 32'hFFFE, 32'h0, 32'hFFFFCAFE, 1'b0, 3);
    txn("lbuffff", 1'b0, 3'b100, 32'hFFFF, 32'h0, 32'h000000CA, 1'b0, 3);
    w0 = wr_cnt;
    txn("lw10000", 1'b0, 3'b010, 32'h10000, 32'h0, 32'h0, 1'b1, 1);
    txn("lwfffd",  1'b0, 3'b010, 32'hFFFD, 32'h0, 32'h0, 1'b1, 1);
    txn("sbtop",   1'b1, 3'b000, 32'hFFFFFFFF, 32'h11, 32'h0, 1'b1, 1);
    txn("shtop",   1'b1, 3'b001, 32'hFFFFFFFE, 32'h11, 32'h0, 1'b1, 1);
    check("range_no_writes", wr_cnt, w0);

    // Back-pressure: response held, new request ignored
    send(1'b0, 3'b010, 32'h10, 32'h0);
    wait_resp(lat);
    check("hold_lat", lat, 3);
    w0 = wr_cnt;
    req_valid  = 1'b1;
    req_write  = 1'b1;
    req_funct3 = 3'b010;
    req_addr   = 32'h50;
    req_wdata  = 32'hAAAAAAAA;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("hold_valid", resp_valid, 1);
      check("hold_rdata", resp_rdata, 32'hDEADBEEF);
      check("hold_ready", req_ready, 0);
    end
    req_valid = 1'b0;
    $display("txn hold     lw 0x10 held 5 cycles rdata=0x%08h", resp_rdata);
    consume();
    check("hold_released", resp_valid, 0);
    check("hold_idle",     req_ready, 1);
    check("hold_no_write", wr_cnt, w0);
    txn("lw50", 1'b0, 3'b010, 32'h50, 32'h0, 32'h0, 1'b0, 3);

    // Reset during a store ACCESS suppresses the write
    txn("sw40a", 1'b1, 3'b010, 32'h40, 32'h11111111, 32'h0, 1'b0, 2);
    w0 = wr_cnt;
    send(1'b1, 3'b010, 32'h40, 32'h12345678);
    rst = 1'b1;
    #1;
    check("rstacc_mem_write", mem_write, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("rstacc_resp_valid", resp_valid, 0);
    check("rstacc_req_ready",  req_ready, 1);
    check("rstacc_mem_addr",   mem_addr, 32'h0);
    check("rstacc_mem_width",  mem_width, 2'b10);
    check("rstacc_mem_din",    mem_din, 32'h0);
    check("rstacc_rdata",      resp_rdata, 32'h0);
    check("rstacc_err",        resp_err, 0);
    check("rstacc_no_write",   wr_cnt, w0);
    $display("txn rstacc   sw 0x40 aborted by reset in ACCESS");
    txn("lw40", 1'b0, 3'b010, 32'h40, 32'h0, 32'h11111111, 1'b0, 3);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
